// File: rtl/riscv_dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the CPU LSU (port 0)
// and a debug/DMA master (port 1). One transaction in flight at a time,
// sequenced IDLE -> ISSUE -> (WAIT_RD) -> RESP, round-robin or CPU-priority.
module riscv_dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned CPU_PRIO = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // port 0: CPU load/store unit
    input  logic          m0_rden,
    input  logic          m0_wren,
    input  logic [AW-1:0] m0_add,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_busy,
    output logic          m0_err,
    // port 1: debug / DMA master
    input  logic          m1_rden,
    input  logic          m1_wren,
    input  logic [AW-1:0] m1_add,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_busy,
    output logic          m1_err,
    // memory controller side
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i,
    input  logic          mem_data_av,
    input  logic          mem_busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = (TW > 8) ? TW : 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q;
    logic            owner_q;
    logic            rd_q;
    logic [AW-1:0]   add_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata0_q, rdata1_q;
    logic            err0_q, err1_q;
    logic [CW-1:0]   cnt_q;

    logic            req0, req1, any_req;
    logic            pick1, pick_rd;
    logic            timeout_hit;
    logic            issue_done;

    assign req0        = m0_rden | m0_wren;
    assign req1        = m1_rden | m1_wren;
    assign any_req     = req0 | req1;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign issue_done  = (state_q == ISSUE) && !mem_busy;

    // Arbitration: a sole requester wins; on a tie, CPU priority or the port not granted last.
    always_comb begin
        pick1   = 1'b0;
        pick_rd = 1'b0;
        if (req0 && req1) begin
            pick1 = (CPU_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            pick1 = req1;
        end
        // rden together with wren is served as a read; the write is picked up by a later grant
        pick_rd = pick1 ? m1_rden : m0_rden;
    end

    // Next-state logic for the issue / wait / response sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (!mem_busy) state_d = rd_q ? WAIT_RD : RESP;
            WAIT_RD: if (mem_data_av || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Grant latch, timeout counter and per-port response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_q         <= 1'b0;
            add_q        <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q      <= pick1;
                last_grant_q <= pick1;
                rd_q         <= pick_rd;
                add_q        <= pick1 ? m1_add : m0_add;
                wdata_q      <= pick1 ? m1_wdata : m0_wdata;
            end

            if (issue_done) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_RD && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // Write completion: clear the owner's error flag, read data is left untouched.
            if (issue_done && !rd_q) begin
                if (owner_q) err1_q <= 1'b0;
                else         err0_q <= 1'b0;
            end

            // Read completion: returned data takes precedence over a simultaneous timeout.
            if (state_q == WAIT_RD && (mem_data_av || timeout_hit)) begin
                if (owner_q) begin
                    rdata1_q <= mem_data_av ? mem_data_i : '0;
                    err1_q   <= ~mem_data_av;
                end else begin
                    rdata0_q <= mem_data_av ? mem_data_i : '0;
                    err0_q   <= ~mem_data_av;
                end
            end
        end
    end

    assign mem_rden   = (state_q == ISSUE) &&  rd_q;
    assign mem_wren   = (state_q == ISSUE) && !rd_q;
    assign mem_add    = add_q;
    assign mem_data_o = wdata_q;

    assign m0_ack   = (state_q == RESP) && !owner_q;
    assign m1_ack   = (state_q == RESP) &&  owner_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;
    assign m0_busy  = rst_ni & req0 & ~m0_ack;
    assign m1_busy  = rst_ni & req1 & ~m1_ack;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter: table of single-port transactions
// with a response scoreboard, plus hand sequences for arbitration, rden+wren,
// early request drop and mid-transaction reset.
module tb_riscv_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_rden = 0, m0_wren = 0, m1_rden = 0, m1_wren = 0;
    logic [AW-1:0] m0_add = '0, m1_add = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_data_av = 0, mem_busy = 0;

    logic [DW-1:0] a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
    logic          a_m0_ack, a_m0_busy, a_m0_err, a_m1_ack, a_m1_busy, a_m1_err;
    logic          b_m0_ack, b_m0_busy, b_m0_err, b_m1_ack, b_m1_busy, b_m1_err;
    logic          a_mem_rden, a_mem_wren, b_mem_rden, b_mem_wren;
    logic [AW-1:0] a_mem_add, b_mem_add;
    logic [DW-1:0] a_mem_data_o, b_mem_data_o;

    always #5 clk = ~clk;

    // round-robin instance
    riscv_dmem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIO(0), .TIMEOUT(TO)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_rden(m0_rden), .m0_wren(m0_wren), .m0_add(m0_add), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_busy(a_m0_busy), .m0_err(a_m0_err),
        .m1_rden(m1_rden), .m1_wren(m1_wren), .m1_add(m1_add), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_busy(a_m1_busy), .m1_err(a_m1_err),
        .mem_rden(a_mem_rden), .mem_wren(a_mem_wren), .mem_add(a_mem_add),
        .mem_data_o(a_mem_data_o), .mem_data_i(mem_data_i),
        .mem_data_av(mem_data_av), .mem_busy(mem_busy)
    );

    // CPU-priority instance
    riscv_dmem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIO(1), .TIMEOUT(TO)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_rden(m0_rden), .m0_wren(m0_wren), .m0_add(m0_add), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_busy(b_m0_busy), .m0_err(b_m0_err),
        .m1_rden(m1_rden), .m1_wren(m1_wren), .m1_add(m1_add), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_busy(b_m1_busy), .m1_err(b_m1_err),
        .mem_rden(b_mem_rden), .mem_wren(b_mem_wren), .mem_add(b_mem_add),
        .mem_data_o(b_mem_data_o), .mem_data_i(mem_data_i),
        .mem_data_av(mem_data_av), .mem_busy(mem_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // av: WAIT_RD cycle (1-based) in which mem_data_av pulses, 0 = never
    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          av;
        int          busy;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } sb_t;

    vec_t vecs[10];
    sb_t  sb_q[$];

    task automatic drive_req(input bit port, input bit rd, input bit wr,
                             input logic [31:0] add, input logic [31:0] wd);
        if (port) begin
            m1_rden = rd; m1_wren = wr; m1_add = add; m1_wdata = wd;
        end else begin
            m0_rden = rd; m0_wren = wr; m0_add = add; m0_wdata = wd;
        end
    endtask

    task automatic drop_all();
        m0_rden = 0; m0_wren = 0; m1_rden = 0; m1_wren = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int  strobes = 0;
        int  wait_k = 0;
        bit  in_wait = 0;
        bit  seen_ack = 0;
        bit  stray_ack = 0;
        sb_t e;
        sb_q.push_back('{port: v.port, rd: v.rd, rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
        @(negedge clk);
        drive_req(v.port, v.rd, !v.rd, v.add, v.wdata);
        mem_busy   = (v.busy > 0);
        mem_data_i = v.mdata;
        for (int cyc = 1; cyc <= 20 && !seen_ack; cyc++) begin
            @(negedge clk);
            mem_data_av = 0;
            if (cyc == 1) chk("busy_while_pending", v.port ? a_m1_busy : a_m0_busy, 1);
            if (a_m0_ack || a_m1_ack) begin
                seen_ack = 1;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("ack_port", {a_m1_ack, a_m0_ack}, e.port ? 2'b10 : 2'b01);
                    chk("ack_latency", cyc, e.lat);
                    chk("ack_err", e.port ? a_m1_err : a_m0_err, e.err);
                    if (e.rd) chk("ack_rdata", e.port ? a_m1_rdata : a_m0_rdata, e.rdata);
                    chk("busy_at_ack", e.port ? a_m1_busy : a_m0_busy, 0);
                end
                drop_all();
                mem_busy = 0;
            end else if (a_mem_rden || a_mem_wren) begin
                strobes++;
                chk("strobe_type", {a_mem_rden, a_mem_wren}, v.rd ? 2'b10 : 2'b01);
                chk("strobe_add", a_mem_add, v.add);
                if (!v.rd) chk("strobe_wdata", a_mem_data_o, v.wdata);
                mem_busy = (strobes <= v.busy);
                if (!mem_busy && v.rd) in_wait = 1;
            end else if (in_wait) begin
                wait_k++;
                mem_data_av = (wait_k == v.av);
            end
            if (v.port ? a_m0_ack : a_m1_ack) stray_ack = 1;
        end
        chk("ack_seen", seen_ack, 1);
        chk("strobe_cycles", strobes, v.busy + 1);
        chk("other_port_no_ack", stray_ack, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_flags", {a_mem_rden, a_mem_wren, a_m0_ack, a_m1_ack, a_m0_busy, a_m1_busy,
                          a_m0_err, a_m1_err}, 0);
        chk("rst_mem_add", a_mem_add, 0);
        chk("rst_mem_data", a_mem_data_o, 0);
        chk("rst_rdata", {a_m0_rdata, a_m1_rdata}, 0);
        drop_all();
        mem_busy = 0; mem_data_av = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int na, nb, nk;
        bit b_ack1;
        vecs[0] = '{0, 1, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 3};
        vecs[1] = '{1, 0, 32'h200, 32'h12345678, 32'h0,        0, 0, 32'h0,        0, 2};
        vecs[2] = '{1, 0, 32'h204, 32'hA5A5A5A5, 32'h0,        0, 5, 32'h0,        0, 7};
        vecs[3] = '{0, 1, 32'h108, 32'h0,        32'h99999999, 0, 0, 32'h0,        1, 6};
        vecs[4] = '{0, 1, 32'h10C, 32'h0,        32'hCAFEF00D, 4, 0, 32'hCAFEF00D, 0, 6};
        vecs[5] = '{1, 1, 32'h208, 32'h0,        32'h0BADF00D, 2, 2, 32'h0BADF00D, 0, 6};
        vecs[6] = '{0, 0, 32'h110, 32'h55AA55AA, 32'h0,        0, 1, 32'h0,        0, 3};
        vecs[7] = '{1, 1, 32'h20C, 32'h0,        32'h11111111, 0, 0, 32'h0,        1, 6};
        vecs[8] = '{0, 1, 32'h114, 32'h0,        32'h87654321, 3, 0, 32'h87654321, 0, 5};
        vecs[9] = '{1, 0, 32'h210, 32'hFFFFFFFF, 32'h0,        0, 0, 32'h0,        0, 2};

        #1;
        chk("por_flags", {a_mem_rden, a_mem_wren, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("scoreboard_drained", sb_q.size(), 0);

        // both ports write continuously: alternation on dut_a, port 0 only on dut_b
        do_reset();
        @(negedge clk);
        drive_req(0, 0, 1, 32'h10, 32'hA0);
        drive_req(1, 0, 1, 32'h20, 32'hB0);
        na = 0; nb = 0; nk = 0; b_ack1 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (a_mem_wren) begin
                chk("rr_add", a_mem_add, (na % 2 == 0) ? 32'h10 : 32'h20);
                chk("rr_strobe_cycle", cyc, 3 * na + 1);
                na++;
            end
            if (a_m0_ack || a_m1_ack) begin
                chk("rr_ack_port", {a_m1_ack, a_m0_ack}, (nk % 2 == 1) ? 2'b10 : 2'b01);
                chk("rr_ack_cycle", cyc, 3 * nk + 2);
                nk++;
            end
            if (b_mem_wren) begin
                chk("prio_add", b_mem_add, 32'h10);
                nb++;
            end
            chk("prio_m1_busy", b_m1_busy, 1);
            if (b_m1_ack) b_ack1 = 1;
        end
        drop_all();
        chk("rr_strobe_count", na, 4);
        chk("rr_ack_count", nk, 4);
        chk("prio_strobe_count", nb, 4);
        chk("prio_m1_never_acked", b_ack1, 0);

        // rden+wren together: read first, write served by the next grant; write request dropped early
        @(negedge clk);
        drive_req(0, 1, 1, 32'h300, 32'h33);
        mem_data_i = 32'h77;
        @(negedge clk);
        chk("dual_read_first", {a_mem_rden, a_mem_wren}, 2'b10);
        chk("dual_add", a_mem_add, 32'h300);
        @(negedge clk);
        mem_data_av = 1;
        @(negedge clk);
        mem_data_av = 0;
        chk("dual_read_ack", a_m0_ack, 1);
        chk("dual_read_data", a_m0_rdata, 32'h77);
        m0_rden = 0;
        @(negedge clk);
        chk("dual_bubble", {a_mem_rden, a_mem_wren, a_m0_ack}, 0);
        @(negedge clk);
        chk("dual_write_next", {a_mem_rden, a_mem_wren}, 2'b01);
        chk("dual_write_data", a_mem_data_o, 32'h33);
        m0_wren = 0;
        @(negedge clk);
        chk("dropped_req_still_acked", a_m0_ack, 1);
        chk("dropped_req_err", a_m0_err, 0);

        // reset while in WAIT_RD, after a port 0 grant (round-robin would now favour port 1)
        @(negedge clk);
        drive_req(0, 1, 0, 32'h400, 32'h0);
        @(negedge clk);
        chk("t6_issue", a_mem_rden, 1);
        @(negedge clk);
        chk("t6_wait_strobes_low", {a_mem_rden, a_mem_wren}, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("t6_rst_flags", {a_mem_rden, a_mem_wren, a_m0_ack, a_m1_ack, a_m0_busy, a_m0_err}, 0);
        chk("t6_rst_add", a_mem_add, 0);
        @(negedge clk);
        drop_all();
        rst_n = 1;
        @(negedge clk);
        chk("t6_no_ack_after_rst", {a_m0_ack, a_m1_ack}, 0);
        drive_req(0, 0, 1, 32'h10, 32'hA0);
        drive_req(1, 0, 1, 32'h20, 32'hB0);
        @(negedge clk);
        chk("t6_port0_wins", {a_mem_wren, a_mem_add}, {1'b1, 32'h10});
        @(negedge clk);
        chk("t6_port0_ack", {a_m1_ack, a_m0_ack}, 2'b01);
        drop_all();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0t required=<100000", $time);
        $fatal(1, "timeout");
    end

endmodule
